// File: rtl/refr_sched_1r1w_rl2.sv
`default_nettype none
// ============================================================================
// Module   : refr_sched_1r1w_rl2
// Purpose  : Front-end scheduler for a 1R1W refresh-capable memory core.
//            Holds off upstream traffic until the memory reports init-done.
//            Generates periodic refresh pulses, placing them in idle cycles
//            when possible. When the refresh debt reaches its bound, it forces
//            a one-cycle stall. It also flags any read return that does not
//            arrive exactly RDLAT cycles after the read command.
// Ports    : clk, rst (sync, active-low)
//            u_read/u_rd_adr/u_rd_rdy            upstream read request/accept
//            u_write/u_wr_adr/u_din/u_wr_rdy     upstream write request/accept
//            m_ready                             memory init-done
//            m_refr/m_read/m_rd_adr              registered commands to memory
//            m_write/m_wr_adr/m_din
//            m_rd_vld                            memory read-data valid
//            lat_err                             sticky read-latency violation
// Revision : 1.0  initial release
// ============================================================================
module refr_sched_1r1w_rl2 #(
    parameter int WIDTH   = 32,
    parameter int BITADDR = 13,
    parameter int REFRESH = 1,
    parameter int REFFREQ = 16,
    parameter int REFDEBT = 4,
    parameter int BITDEBT = 3,
    parameter int RDLAT   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               u_read,
    input  logic [BITADDR-1:0] u_rd_adr,
    output logic               u_rd_rdy,
    input  logic               u_write,
    input  logic [BITADDR-1:0] u_wr_adr,
    input  logic [WIDTH-1:0]   u_din,
    output logic               u_wr_rdy,
    input  logic               m_ready,
    output logic               m_refr,
    output logic               m_read,
    output logic [BITADDR-1:0] m_rd_adr,
    output logic               m_write,
    output logic [BITADDR-1:0] m_wr_adr,
    output logic [WIDTH-1:0]   m_din,
    input  logic               m_rd_vld,
    output logic               lat_err
);

    localparam int                 C_TMR_W    = $clog2(REFFREQ);
    localparam logic [C_TMR_W-1:0] C_TMR_LAST = C_TMR_W'(REFFREQ - 1);
    localparam logic [BITDEBT-1:0] C_DEBT_MAX = BITDEBT'(REFDEBT);
    localparam logic               C_REFR_EN  = (REFRESH != 0);

    localparam logic [0:0] C_ST_INIT = 1'b0;
    localparam logic [0:0] C_ST_RUN  = 1'b1;

    logic [0:0]         state_q,    state_d;
    logic [C_TMR_W-1:0] timer_q,    timer_d;
    logic [BITDEBT-1:0] debt_q,     debt_d;
    logic               m_refr_q,   m_refr_d;
    logic               m_read_q,   m_read_d;
    logic [BITADDR-1:0] m_rd_adr_q, m_rd_adr_d;
    logic               m_write_q,  m_write_d;
    logic [BITADDR-1:0] m_wr_adr_q, m_wr_adr_d;
    logic [WIDTH-1:0]   m_din_q,    m_din_d;
    logic [RDLAT-1:0]   chk_q,      chk_d;
    logic               lat_err_q,  lat_err_d;

    logic w_run;
    logic w_debt_full;
    logic w_wrap;
    logic w_issue;
    logic w_acc_rd;
    logic w_acc_wr;

    assign w_run       = (state_q == C_ST_RUN);
    assign w_debt_full = C_REFR_EN && (debt_q == C_DEBT_MAX);
    assign w_wrap      = w_run && C_REFR_EN && (timer_q == C_TMR_LAST);
    // Refresh goes out on an idle cycle, or unconditionally once debt is full
    // (the ready outputs are dropped in that same cycle to make room).
    assign w_issue     = w_run && C_REFR_EN && (debt_q != '0) &&
                         ((!u_read && !u_write) || w_debt_full);
    assign w_acc_rd    = u_read  && u_rd_rdy;
    assign w_acc_wr    = u_write && u_wr_rdy;

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (state_q == C_ST_INIT && m_ready) begin
            state_d = C_ST_RUN;
        end
    end

    // ---------------- FSM: outputs (state and debt only) ----------------
    always_comb begin
        u_rd_rdy = 1'b0;
        u_wr_rdy = 1'b0;
        if (w_run && !w_debt_full) begin
            u_rd_rdy = 1'b1;
            u_wr_rdy = 1'b1;
        end
    end

    // ---------------- refresh timer and debt ----------------
    always_comb begin
        timer_d = '0;
        debt_d  = '0;
        if (w_run && C_REFR_EN) begin
            timer_d = w_wrap ? '0 : timer_q + C_TMR_W'(1);
            debt_d  = debt_q;
            if (w_wrap && !w_issue) begin
                debt_d = debt_q + BITDEBT'(1);
            end else if (!w_wrap && w_issue) begin
                debt_d = debt_q - BITDEBT'(1);
            end
        end
    end

    // ---------------- issue stage ----------------
    always_comb begin
        m_refr_d   = w_issue;
        m_read_d   = w_acc_rd;
        m_write_d  = w_acc_wr;
        m_rd_adr_d = w_acc_rd ? u_rd_adr : m_rd_adr_q;
        m_wr_adr_d = w_acc_wr ? u_wr_adr : m_wr_adr_q;
        m_din_d    = w_acc_wr ? u_din    : m_din_q;
    end

    // ---------------- read-latency checker ----------------
    generate
        if (RDLAT == 1) begin : g_chk_one
            assign chk_d = m_read_q;
        end else begin : g_chk_deep
            assign chk_d = {chk_q[RDLAT-2:0], m_read_q};
        end
    endgenerate

    assign lat_err_d = lat_err_q | (m_rd_vld != chk_q[RDLAT-1]);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= C_ST_INIT;
            timer_q    <= '0;
            debt_q     <= '0;
            m_refr_q   <= 1'b0;
            m_read_q   <= 1'b0;
            m_rd_adr_q <= '0;
            m_write_q  <= 1'b0;
            m_wr_adr_q <= '0;
            m_din_q    <= '0;
            chk_q      <= '0;
            lat_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            debt_q     <= debt_d;
            m_refr_q   <= m_refr_d;
            m_read_q   <= m_read_d;
            m_rd_adr_q <= m_rd_adr_d;
            m_write_q  <= m_write_d;
            m_wr_adr_q <= m_wr_adr_d;
            m_din_q    <= m_din_d;
            chk_q      <= chk_d;
            lat_err_q  <= lat_err_d;
        end
    end

    assign m_refr   = m_refr_q;
    assign m_read   = m_read_q;
    assign m_rd_adr = m_rd_adr_q;
    assign m_write  = m_write_q;
    assign m_wr_adr = m_wr_adr_q;
    assign m_din    = m_din_q;
    assign lat_err  = lat_err_q;

endmodule
`default_nettype wire

// File: tb/tb_refr_sched_1r1w_rl2.sv
`default_nettype none
// ============================================================================
// Module   : tb_refr_sched_1r1w_rl2
// Purpose  : Self-checking bench for refr_sched_1r1w_rl2. A cycle-level
//            behavioural model (refresh credits from the RUN cycle count,
//            a pending-refresh integer, and a history of read-command cycles)
//            predicts every output on every cycle. Directed scenarios pin the
//            model against hand-computed cycle numbers.
// Revision : 1.0  initial release
// ============================================================================
module tb_refr_sched_1r1w_rl2;

    localparam int WIDTH   = 32;
    localparam int BITADDR = 13;
    localparam int REFRESH = 1;
    localparam int REFFREQ = 16;
    localparam int REFDEBT = 4;
    localparam int BITDEBT = 3;
    localparam int RDLAT   = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               u_read, u_write, m_ready, m_rd_vld;
    logic [BITADDR-1:0] u_rd_adr, u_wr_adr;
    logic [WIDTH-1:0]   u_din;
    logic               u_rd_rdy, u_wr_rdy, m_refr, m_read, m_write, lat_err;
    logic [BITADDR-1:0] m_rd_adr, m_wr_adr;
    logic [WIDTH-1:0]   m_din;

    refr_sched_1r1w_rl2 #(
        .WIDTH(WIDTH), .BITADDR(BITADDR), .REFRESH(REFRESH), .REFFREQ(REFFREQ),
        .REFDEBT(REFDEBT), .BITDEBT(BITDEBT), .RDLAT(RDLAT)
    ) dut (
        .clk(clk), .rst(rst),
        .u_read(u_read), .u_rd_adr(u_rd_adr), .u_rd_rdy(u_rd_rdy),
        .u_write(u_write), .u_wr_adr(u_wr_adr), .u_din(u_din), .u_wr_rdy(u_wr_rdy),
        .m_ready(m_ready), .m_refr(m_refr),
        .m_read(m_read), .m_rd_adr(m_rd_adr),
        .m_write(m_write), .m_wr_adr(m_wr_adr), .m_din(m_din),
        .m_rd_vld(m_rd_vld), .lat_err(lat_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state for the cycle currently being driven.
    bit                 model_run = 1'b0;
    int                 pending   = 0;
    int                 run_cyc   = 0;
    int                 cyc       = 0;
    logic               e_refr = 1'b0, e_read = 1'b0, e_write = 1'b0, e_lat = 1'b0;
    logic [BITADDR-1:0] e_rd_adr = '0, e_wr_adr = '0;
    logic [WIDTH-1:0]   e_din = '0;
    bit                 hist[int];      // cycles in which m_read must be high
    int                 refr_q[$];      // RUN cycles where m_refr was seen high
    int                 stall_q[$];     // RUN cycles where ready was seen low
    bit                 auto_vld = 1'b1;
    bit                 vld_flip = 1'b0;
    logic               s_rdy;
    int                 p;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: inputs are already driven by the caller.
    task automatic step();
        bit rdy, idle, ref_now, wrap, acc_r, acc_w, exp_vld;
        if (auto_vld) m_rd_vld = (hist.exists(cyc - RDLAT) != 0) ^ vld_flip;
        #1;
        rdy   = model_run && (pending != REFDEBT);
        s_rdy = u_rd_rdy;
        if (model_run && !u_rd_rdy) stall_q.push_back(run_cyc);
        chk("u_rd_rdy", u_rd_rdy, rdy);
        chk("u_wr_rdy", u_wr_rdy, rdy);
        if (!rst) begin
            model_run = 1'b0; pending = 0; run_cyc = 0;
            e_refr = 0; e_read = 0; e_write = 0; e_lat = 0;
            e_rd_adr = '0; e_wr_adr = '0; e_din = '0;
            hist.delete();
        end else begin
            idle    = !u_read && !u_write;
            ref_now = model_run && pending > 0 && (idle || pending == REFDEBT);
            wrap    = model_run && (run_cyc % REFFREQ == REFFREQ - 1);
            acc_r   = u_read && rdy;
            acc_w   = u_write && rdy;
            exp_vld = (hist.exists(cyc - RDLAT) != 0);
            e_refr  = ref_now;
            e_read  = acc_r;
            e_write = acc_w;
            if (acc_r) begin
                e_rd_adr = u_rd_adr;
                hist[cyc + 1] = 1'b1;
            end
            if (acc_w) begin
                e_wr_adr = u_wr_adr;
                e_din    = u_din;
            end
            if (m_rd_vld != exp_vld) e_lat = 1'b1;
            pending = pending + int'(wrap) - int'(ref_now);
            if (model_run) run_cyc++;
            else if (m_ready) begin
                model_run = 1'b1;
                run_cyc   = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (model_run && m_refr) refr_q.push_back(run_cyc);
        chk("m_refr",   m_refr,   e_refr);
        chk("m_read",   m_read,   e_read);
        chk("m_rd_adr", m_rd_adr, e_rd_adr);
        chk("m_write",  m_write,  e_write);
        chk("m_wr_adr", m_wr_adr, e_wr_adr);
        chk("m_din",    m_din,    e_din);
        chk("lat_err",  lat_err,  e_lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_idle[3];
        int exp_stall[3];
        int exp_frc[3];
        exp_idle  = '{17, 33, 49};
        exp_stall = '{64, 80, 96};
        exp_frc   = '{65, 81, 97};

        rst = 1'b0; u_read = 0; u_write = 0; u_rd_adr = '0; u_wr_adr = '0;
        u_din = '0; m_ready = 0; m_rd_vld = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then m_ready rises in release cycle 10.
        step();
        rst = 1'b1;
        refr_q.delete();
        for (int i = 0; i <= 11; i++) begin
            m_ready = (i >= 10);
            step();
            if (i == 10) chk("init_rdy_c10", s_rdy, 1'b0);
            if (i == 11) chk("run_rdy_c11", s_rdy, 1'b1);
        end
        chk("init_no_refr", refr_q.size(), 0);

        // Idle upstream: refresh pulses at RUN cycles 17, 33, 49.
        for (int k = 0; k < 200 && run_cyc < 56; k++) step();
        chk("idle_refr_cnt", refr_q.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("idle_refr_at", (i < refr_q.size()) ? refr_q[i] : -1, exp_idle[i]);

        // Continuous reads from RUN cycle 0: forced stalls every 16 cycles.
        rst = 1'b0;
        step();
        rst = 1'b1; m_ready = 1'b1; u_read = 1'b1;
        refr_q.delete(); stall_q.delete();
        for (int k = 0; k < 300 && !(model_run && run_cyc >= 100); k++) begin
            u_rd_adr = BITADDR'($urandom);
            step();
        end
        chk("stall_cnt", stall_q.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("stall_at", (i < stall_q.size()) ? stall_q[i] : -1, exp_stall[i]);
        chk("forced_refr_cnt", refr_q.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("forced_refr_at", (i < refr_q.size()) ? refr_q[i] : -1, exp_frc[i]);

        // Read and write accepted together.
        u_read = 1'b1; u_rd_adr = 13'h0A5;
        u_write = 1'b1; u_wr_adr = 13'h1F0; u_din = 32'hDEADBEEF;
        step();
        chk("rw_read",   m_read,   1'b1);
        chk("rw_rd_adr", m_rd_adr, 32'h0A5);
        chk("rw_write",  m_write,  1'b1);
        chk("rw_wr_adr", m_wr_adr, 32'h1F0);
        chk("rw_din",    m_din,    32'hDEADBEEF);
        chk("rw_refr",   m_refr,   1'b0);
        u_read = 1'b0; u_write = 1'b0;

        // Reset with debt 3 and a read in flight; m_rd_vld ignored in reset.
        rst = 1'b0; auto_vld = 1'b0; m_rd_vld = 1'b1;
        step();
        chk("rst_read", m_read, 1'b0);
        chk("rst_refr", m_refr, 1'b0);
        chk("rst_lat",  lat_err, 1'b0);
        rst = 1'b1; m_ready = 1'b0; m_rd_vld = 1'b0; auto_vld = 1'b1;
        refr_q.delete();
        repeat (8) step();
        chk("post_rst_lat", lat_err, 1'b0);
        chk("post_rst_refr", refr_q.size(), 0);

        // Late read return: valid arrives one cycle after its slot.
        m_ready = 1'b1;
        repeat (3) step();
        u_read = 1'b1; u_rd_adr = 13'h005;
        step();
        u_read = 1'b0; auto_vld = 1'b0; m_rd_vld = 1'b0;
        repeat (4) step();
        chk("lat_late_set", lat_err, 1'b1);
        m_rd_vld = 1'b1;
        step();
        m_rd_vld = 1'b0;
        repeat (5) step();
        chk("lat_sticky", lat_err, 1'b1);

        // Stray valid with nothing outstanding.
        rst = 1'b0;
        step();
        rst = 1'b1; auto_vld = 1'b1;
        repeat (4) step();
        chk("lat_clear", lat_err, 1'b0);
        auto_vld = 1'b0; m_rd_vld = 1'b1;
        step();
        m_rd_vld = 1'b0;
        chk("lat_stray", lat_err, 1'b1);
        step();
        chk("lat_stray_sticky", lat_err, 1'b1);
        auto_vld = 1'b1;

        // Randomized traffic with occasional resets and bad returns.
        p = 50;
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       p = 20;
                    1:       p = 70;
                    default: p = 97;
                endcase
            end
            rst      = ($urandom_range(0, 299) != 0);
            m_ready  = ($urandom_range(0, 3) == 0);
            u_read   = ($urandom_range(0, 99) < p);
            u_write  = ($urandom_range(0, 99) < p);
            u_rd_adr = BITADDR'($urandom);
            u_wr_adr = BITADDR'($urandom);
            u_din    = $urandom;
            vld_flip = ($urandom_range(0, 499) == 0);
            step();
        end
        vld_flip = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/refr_sched_1r1w_rl2.md
# refr_sched_1r1w_rl2

Front-end scheduler for the 1R1W refresh-capable memory core. It gates upstream read and write requests until the memory reports ready, and generates the periodic `refr` pulses the core needs. Refreshes are slotted into idle cycles where possible; a bounded refresh debt forces a one-cycle upstream stall when no idle cycle arrives. The block also checks that every issued read returns exactly `RDLAT` cycles later. It sits between the requesting client and the memory top level, driving that top level's `refr`, `read` and `write` inputs.

## Interface
Parameters:
- WIDTH, 32, data width
- BITADDR, 13, address width
- REFRESH, 1, 1 = refresh generation enabled; 0 = `m_refr` tied 0, no stalls
- REFFREQ, 16, cycles per refresh credit (>= 2)
- REFDEBT, 4, maximum pending refreshes before forcing (>= 1)
- BITDEBT, 3, width of the debt counter (holds 0..REFDEBT)
- RDLAT, 3, memory read latency from `m_read` to `m_rd_vld` (>= 1)

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-low (0 = reset); one clock, reset is synchronous and active-low
- u_read  input  1  upstream read request
- u_rd_adr  input  BITADDR  upstream read address
- u_rd_rdy  output  1  read accepted this cycle when high with `u_read`
- u_write  input  1  upstream write request
- u_wr_adr  input  BITADDR  upstream write address
- u_din  input  WIDTH  upstream write data
- u_wr_rdy  output  1  write accepted this cycle when high with `u_write`
- m_ready  input  1  memory init-done
- m_refr  output  1  refresh pulse to memory
- m_read  output  1  read command to memory
- m_rd_adr  output  BITADDR  read address to memory
- m_write  output  1  write command to memory
- m_wr_adr  output  BITADDR  write address to memory
- m_din  output  WIDTH  write data to memory
- m_rd_vld  input  1  memory read-data valid
- lat_err  output  1  sticky read-latency violation

## Operation
- The state machine has two states, INIT and RUN. Reset enters INIT.
  - INIT → RUN on the first clock edge with `m_ready` = 1.
  - RUN is left only by reset.
  - `m_ready` falling while in RUN is ignored.
- In INIT: `u_rd_rdy` = `u_wr_rdy` = 0; the refresh timer and debt are held at 0.
- The refresh timer counts 0..REFFREQ-1 in RUN and wraps. A wrap (timer == REFFREQ-1) makes a credit available.
- Debt counter update each cycle: debt_next = debt + wrap − issue.
- Refresh issue decision, evaluated in RUN when debt > 0:
  - Idle issue: `u_read` = 0 and `u_write` = 0.
  - Forced issue: debt == REFDEBT. In that cycle `u_rd_rdy` = `u_wr_rdy` = 0 regardless of requests.
- By construction debt never exceeds REFDEBT. A wrap and an issue in the same cycle leave debt unchanged.
- Ready outputs: `u_rd_rdy` = `u_wr_rdy` = (RUN) & ~(REFRESH & debt == REFDEBT). They are combinational from state and debt only, never from the `u_*` request inputs.
- Issue stage, all outputs registered:
  - An accepted read drives `m_read` = 1 and `m_rd_adr` next cycle.
  - An accepted write drives `m_write`, `m_wr_adr`, `m_din` next cycle.
  - An issue decision drives `m_refr` = 1 next cycle.
  - A read and a write may be accepted in the same cycle and issue together.
  - `m_refr` is never high in the same cycle as `m_read` or `m_write`.
  - Address and data outputs hold their last value when their command is 0.
- Latency checker: an RDLAT-deep shift register is loaded with `m_read`. `lat_err` is set the cycle after `m_rd_vld` differs from the shift-register output, and stays set until reset.
- REFRESH = 0: no debt, `m_refr` = 0, ready outputs = RUN.

## Timing
- Reset values: all outputs 0, timer 0, debt 0, checker pipeline cleared, `lat_err` 0.
- Reset asserted mid-operation:
  - Next edge: outputs 0 and pending debt discarded.
  - In-flight reads are dropped from the checker.
  - `m_rd_vld` is ignored while `rst` = 0.
- Request → command latency: 1 cycle. Credit → idle refresh: 2 cycles minimum (wrap edge, decision, registered pulse).
- A forced stall lasts exactly one cycle per forced refresh. Under continuous traffic the steady state is one stall every REFFREQ cycles.
- Timing reference used below: RUN cycle 0 is the first cycle in RUN.

## Test plan
- Release reset; `m_ready` rises at cycle 10 → ready outputs 0 through cycle 10 and 1 from cycle 11; `m_refr` stays 0 throughout INIT.
- REFFREQ = 16, upstream idle → `m_refr` single-cycle pulses at RUN cycles 17, 33, 49; debt returns to 0 after each.
- Continuous `u_read`, REFDEBT = 4 → debt reaches 4 at RUN cycle 64; ready outputs 0 in cycle 64 only; `m_refr` = 1 and `m_read` = 0 at cycle 65; thereafter one stall every 16 cycles.
- `u_read` (adr 0x0A5) and `u_write` (adr 0x1F0, data 0xDEADBEEF) in the same accepted cycle → next cycle `m_read` = 1, `m_write` = 1 with those values, `m_refr` = 0.
- RDLAT = 3, issue a read, drive `m_rd_vld` 4 cycles later → `lat_err` = 1 one cycle after the expected slot, and stays 1; a stray `m_rd_vld` with no read outstanding also sets it.
- Debt = 3 with reads in flight, assert `rst` = 0 for one cycle → all outputs 0 next edge, no `m_refr` and no `lat_err` after release until new activity.
